dcache_mem_responder: RTL
=========================

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

Interface
REQ-001 SHALL have parameter offset_width, default 2, log2 of words per line; LW = 2^offset_width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rstn  in  1  reset; reset rstn, asynchronous, active-low; clock clk.
- dcache_mem_req  in  1  request valid; held by the Dcache until addrOK.
- dcache_mem_wr  in  1  1 = write, 0 = read.
- dcache_mem_size  in  2  0 = 1B, 1 = 2B, 2 = 4B; forwarded on writes.
- dcache_mem_wstrb  in  4  write byte enables.
- dcache_mem_suc  in  1  strongly-ordered uncached access.
- dcache_mem_addr  in  32  byte address.
- dcache_mem_wdata  in  32  write data.
- mem_dcache_addrOK  out  1  request accepted.
- mem_dcache_dataOK  out  1  read line valid, 1-cycle pulse.
- mem_dcache_bvalid  out  1  write completed, 1-cycle pulse.
- mem_dcache_rdata  out  32*LW  line data; word i in bits [32i+31:32i].
- bus_req  out  1  bus beat request; held until bus_gnt.
- bus_we  out  1  bus write.
- bus_addr  out  32  word-aligned beat address.
- bus_wdata  out  32  beat write data.
- bus_wstrb  out  4  beat byte enables.
- bus_size  out  2  beat size.
- bus_gnt  in  1  beat accepted.
- bus_rvalid  in  1  read beat data valid.
- bus_rdata  in  32  read beat data.
- bus_wack  in  1  write acknowledged.

Function
REQ-003 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, RD_DONE, WR_ISSUE, WR_WAIT.
REQ-004 SHALL capture addr, wdata, wstrb, size, wr and suc into a request register on the acceptance cycle, which is IDLE with dcache_mem_req high; next state is RD_ISSUE for reads and WR_ISSUE for writes.
REQ-005 SHALL drive addrOK combinationally high in the acceptance cycle for reads; write addrOK timing follows REQ-016/017.
REQ-006 SHALL ignore dcache_mem_req in every state other than IDLE.
REQ-007 SHALL, for a cached read, issue LW beats at base = addr with bits [offset_width+1:0] cleared, beat k at base+4k, k = 0..LW-1 ascending.
REQ-008 SHALL, for a suc read, issue exactly 1 beat at addr[31:2],2'b00 and store the data in lane addr[offset_width+1:2]; other lanes hold stale data.
REQ-009 SHALL allow at most one outstanding beat: RD_ISSUE holds bus_req until bus_gnt, then moves to RD_WAIT; RD_WAIT waits for bus_rvalid, writes the lane, and returns to RD_ISSUE or goes to RD_DONE after the last beat.
REQ-010 SHALL use a beat counter of offset_width bits that wraps to 0 after the last beat.
REQ-011 SHALL pulse dataOK for exactly 1 cycle in RD_DONE with rdata stable, then return to IDLE; rdata holds until the next read's first rvalid.
REQ-012 SHALL have WR_ISSUE hold bus_req=1, bus_we=1 with the captured addr/wdata/wstrb/size until bus_gnt, then move to WR_WAIT.
REQ-013 SHALL have WR_WAIT pulse bvalid in the cycle bus_wack is seen, then return to IDLE.
REQ-014 SHALL ignore bus_rvalid outside RD_WAIT and bus_wack outside WR_WAIT.
REQ-015 SHALL treat bus_gnt and bus_rvalid in the same cycle in RD_ISSUE as gnt only; rvalid is not accepted before RD_WAIT.

Configuration
REQ-016 SHALL, with WRITE_POST_EN defined, assert write addrOK in the acceptance cycle (posted write), with bvalid still per REQ-013.
REQ-017 SHALL, without WRITE_POST_EN, raise write addrOK only in the WR_WAIT cycle where bus_wack is high, coincident with bvalid; the Dcache keeps req high meanwhile.

Reset
REQ-018 SHALL, on rstn low, immediately force state IDLE, counter 0, request register 0, rdata 0, and all outputs 0, including during an in-flight burst; no pending beat is resumed.

Structure
REQ-019 SHALL put state encodings and size codes (SIZE_B=0, SIZE_H=1, SIZE_W=2) in shared package dcache_mem_pkg.
REQ-020 SHALL use no sub-module; the line buffer is a flat register array in this module.

Verification
REQ-021 SHALL cover: cached read addr 0x1000_0014, offset_width 2, gnt/rvalid 1 cycle each, data 0xA0..0xA3 -> beats at 0x1000_0010/14/18/1C; dataOK 1 pulse; rdata = {A3,A2,A1,A0}.
REQ-022 SHALL cover: suc read 0x2000_0008, rdata 0x55AA -> 1 beat at 0x2000_0008; lane 2 = 0x55AA; dataOK 1 pulse.
REQ-023 SHALL cover: write 0x3000_0004, wstrb 4'b0011, wack 3 cycles after gnt -> with WRITE_POST_EN, addrOK in the acceptance cycle; without it, addrOK and bvalid coincide on wack.
REQ-024 SHALL cover: bus_gnt delayed 5 cycles on beat 2 -> bus_req and bus_addr stable the whole time; no dataOK before beat 3 returns.
REQ-025 SHALL cover: rstn low after beat 1 of 4, then a new read -> all outputs 0; the new read restarts at beat 0 with no stray dataOK.
REQ-026 SHALL cover: req held high through a read, req high in RD_WAIT -> no second capture; exactly 1 addrOK per request.

Source files
------------

// File: rtl/dcache_mem_pkg.sv
// Shared definitions for the Dcache memory responder: FSM state encodings and bus size codes.
`default_nettype none

package dcache_mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_DONE  = 3'd3,
        WR_ISSUE = 3'd4,
        WR_WAIT  = 3'd5
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dcache_mem_responder_if.sv
// Dcache-side request/response signals plus the single-beat memory bus, bundled for the responder.
`default_nettype none

interface dcache_mem_responder_if #(
    parameter int offset_width = 2
) ();
    localparam int LW = 1 << offset_width;

    logic                 dcache_mem_req;
    logic                 dcache_mem_wr;
    logic [1:0]           dcache_mem_size;
    logic [3:0]           dcache_mem_wstrb;
    logic                 dcache_mem_suc;
    logic [31:0]          dcache_mem_addr;
    logic [31:0]          dcache_mem_wdata;
    logic                 mem_dcache_addrOK;
    logic                 mem_dcache_dataOK;
    logic                 mem_dcache_bvalid;
    logic [32*LW-1:0]     mem_dcache_rdata;
    logic                 bus_req;
    logic                 bus_we;
    logic [31:0]          bus_addr;
    logic [31:0]          bus_wdata;
    logic [3:0]           bus_wstrb;
    logic [1:0]           bus_size;
    logic                 bus_gnt;
    logic                 bus_rvalid;
    logic [31:0]          bus_rdata;
    logic                 bus_wack;

    // Responder side.
    modport slave (
        input  dcache_mem_req, dcache_mem_wr, dcache_mem_size, dcache_mem_wstrb,
               dcache_mem_suc, dcache_mem_addr, dcache_mem_wdata,
               bus_gnt, bus_rvalid, bus_rdata, bus_wack,
        output mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid, mem_dcache_rdata,
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size
    );

    // Dcache plus memory-bus side.
    modport master (
        output dcache_mem_req, dcache_mem_wr, dcache_mem_size, dcache_mem_wstrb,
               dcache_mem_suc, dcache_mem_addr, dcache_mem_wdata,
               bus_gnt, bus_rvalid, bus_rdata, bus_wack,
        input  mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid, mem_dcache_rdata,
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size
    );

endinterface

`default_nettype wire

// File: rtl/dcache_mem_responder.sv
// Turns Dcache line reads / single writes into one-outstanding-beat bus transactions.
// Build option: define WRITE_POST_EN to acknowledge writes (addrOK) at acceptance.
`default_nettype none

module dcache_mem_responder
    import dcache_mem_pkg::*;
#(
    parameter int offset_width = 2
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    dcache_mem_responder_if.slave io
);
    localparam int LW = 1 << offset_width;
    localparam logic [offset_width-1:0] LAST_BEAT = offset_width'(LW - 1);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << (offset_width + 2)) - 32'd1);
`ifdef WRITE_POST_EN
    localparam bit POSTED_WRITE = 1'b1;
`else
    localparam bit POSTED_WRITE = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [offset_width-1:0] cnt_q, cnt_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [1:0]              size_q, size_d;
    logic                    wr_q, wr_d;
    logic                    suc_q, suc_d;
    logic [31:0]             line_q [LW];
    logic [31:0]             line_d [LW];

    logic                    addr_ok, data_ok, bvalid;
    logic                    bus_req, bus_we;
    logic [31:0]             bus_addr, bus_wdata;
    logic [3:0]              bus_wstrb;
    logic [1:0]              bus_size;
    logic [offset_width-1:0] lane;

    assign lane = suc_q ? addr_q[offset_width+1:2] : cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            suc_q   <= 1'b0;
            for (int i = 0; i < LW; i++) line_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            suc_q   <= suc_d;
            for (int i = 0; i < LW; i++) line_q[i] <= line_d[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        wr_d      = wr_q;
        suc_d     = suc_q;
        line_d    = line_q;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        bvalid    = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
        bus_size  = '0;

        case (state_q)
            IDLE: begin
                if (io.dcache_mem_req) begin
                    addr_d  = io.dcache_mem_addr;
                    wdata_d = io.dcache_mem_wdata;
                    wstrb_d = io.dcache_mem_wstrb;
                    size_d  = io.dcache_mem_size;
                    wr_d    = io.dcache_mem_wr;
                    suc_d   = io.dcache_mem_suc;
                    cnt_d   = '0;
                    // Gated by rstn so the combinational ack is also quiet under reset.
                    addr_ok = rstn && (!io.dcache_mem_wr || POSTED_WRITE);
                    state_d = io.dcache_mem_wr ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                bus_req   = 1'b1;
                bus_wstrb = 4'hF;
                bus_size  = suc_q ? size_q : SIZE_W;
                bus_addr  = suc_q ? (addr_q & ~32'h3)
                                  : ((addr_q & LINE_MASK) | (32'(cnt_q) << 2));
                if (io.bus_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (io.bus_rvalid) begin
                    line_d[lane] = io.bus_rdata;
                    cnt_d        = suc_q ? '0 : cnt_q + 1'b1;
                    state_d      = (suc_q || cnt_q == LAST_BEAT) ? RD_DONE : RD_ISSUE;
                end
            end
            RD_DONE: begin
                data_ok = 1'b1;
                state_d = IDLE;
            end
            WR_ISSUE: begin
                bus_req   = 1'b1;
                bus_we    = wr_q;
                bus_addr  = addr_q & ~32'h3;
                bus_wdata = wdata_q;
                bus_wstrb = wstrb_q;
                bus_size  = size_q;
                if (io.bus_gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (io.bus_wack) begin
                    bvalid  = 1'b1;
                    addr_ok = !POSTED_WRITE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.mem_dcache_addrOK = addr_ok;
    assign io.mem_dcache_dataOK = data_ok;
    assign io.mem_dcache_bvalid = bvalid;
    assign io.bus_req           = bus_req;
    assign io.bus_we            = bus_we;
    assign io.bus_addr          = bus_addr;
    assign io.bus_wdata         = bus_wdata;
    assign io.bus_wstrb         = bus_wstrb;
    assign io.bus_size          = bus_size;

    for (genvar i = 0; i < LW; i++) begin : g_rdata
        assign io.mem_dcache_rdata[32*i +: 32] = line_q[i];
    end

endmodule

`default_nettype wire
